// File: rtl/wave_pkg.sv
// Shared types and defaults for the phase-accumulator oscillator and its shaper.
// shaper_width gives how many top phase bits the shaper actually consumes.
package wave_pkg;

  typedef enum logic [1:0] {
    SHAPE_SAW    = 2'd0,
    SHAPE_TRI    = 2'd1,
    SHAPE_SQUARE = 2'd2,
    SHAPE_PULSE  = 2'd3
  } shape_e;

  localparam int WAVE_P_DEFAULT = 16;
  localparam int WAVE_N_DEFAULT = 11;
  localparam int WAVE_D_DEFAULT = 8;

  // Saw/tri need N+1 top bits, pulse needs D top bits; nothing below that matters.
  function automatic int shaper_width(input int n, input int d);
    return (n + 1 > d) ? n + 1 : d;
  endfunction

endpackage

// File: rtl/wave_shaper.sv
// Combinational shape generator: maps the top phase bits plus shape/duty to one sample.
// phase is the top W bits of the accumulator; lower bits never affect any shape.
module wave_shaper
  import wave_pkg::*;
#(
  parameter int N = WAVE_N_DEFAULT,
  parameter int D = WAVE_D_DEFAULT,
  parameter int W = shaper_width(N, D)
) (
  input  logic [W-1:0] phase,
  input  shape_e       shape,
  input  logic [D-1:0] duty,
  output logic [N-1:0] sample
);

  logic [N-1:0] tri_fold;

  // Triangle folds the lower half-period: XOR with the MSB inverts the second half.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_tri
      assign tri_fold[gi] = phase[W-1-N+gi] ^ phase[W-1];
    end
  endgenerate

  always_comb begin
    sample = '0;
    case (shape)
      SHAPE_SAW:    sample = phase[W-1 -: N];
      SHAPE_TRI:    sample = tri_fold;
      SHAPE_SQUARE: sample = phase[W-1] ? '0 : '1;
      SHAPE_PULSE:  sample = (phase[W-1 -: D] < duty) ? '1 : '0;
      default:      sample = '0;
    endcase
  end

endmodule

// File: rtl/wave_generator.sv
// Phase-accumulator oscillator with hard-sync, registered output and shape/duty
// changes deferred to period boundaries so no period mixes two shapes.
module wave_generator
  import wave_pkg::*;
#(
  parameter int P = WAVE_P_DEFAULT,
  parameter int N = WAVE_N_DEFAULT,
  parameter int D = WAVE_D_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [P-1:0] freq,
  input  logic [1:0]   shape_in,
  input  logic [D-1:0] duty_in,
  input  logic         sync,
  output logic [N-1:0] wave,
  output logic         wrap,
  output logic [1:0]   shape_active
);

  localparam int W = shaper_width(N, D);

  logic [P-1:0] phase_reg, phase_next;
  logic         wrap_reg, wrap_next;
  shape_e       shape_reg, shape_next;
  logic [D-1:0] duty_reg, duty_next;
  logic [N-1:0] wave_reg, sample;
  logic [P:0]   sum;
  logic         carry;
  logic         reload;

  always_comb begin
    sum        = {1'b0, phase_reg} + {1'b0, freq};
    carry      = ena & sum[P];
    reload     = sync | carry;
    phase_next = phase_reg;
    if (sync) begin
      phase_next = '0;
    end else if (ena) begin
      phase_next = sum[P-1:0];
    end
    wrap_next  = reload;
    shape_next = shape_reg;
    duty_next  = duty_reg;
    // New shape/duty are picked up only when a fresh period begins.
    if (reload) begin
      shape_next = shape_e'(shape_in);
      duty_next  = duty_in;
    end
  end

  wave_shaper #(
    .N(N),
    .D(D),
    .W(W)
  ) u_shaper (
    .phase (phase_reg[P-1 -: W]),
    .shape (shape_reg),
    .duty  (duty_reg),
    .sample(sample)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_reg <= '0;
      wrap_reg  <= 1'b0;
      wave_reg  <= '0;
      shape_reg <= shape_e'(shape_in);
      duty_reg  <= duty_in;
    end else begin
      phase_reg <= phase_next;
      wrap_reg  <= wrap_next;
      wave_reg  <= sample;
      shape_reg <= shape_next;
      duty_reg  <= duty_next;
    end
  end

  assign wave         = wave_reg;
  assign wrap         = wrap_reg;
  assign shape_active = shape_reg;

endmodule

// File: tb/tb_wave_generator.sv
// Self-checking bench for wave_generator (P=16, N=11, D=8) against an integer model.
module tb_wave_generator;

  logic        clk;
  logic        rst;
  logic        ena;
  logic [15:0] freq;
  logic [1:0]  shape_in;
  logic [7:0]  duty_in;
  logic        sync;
  logic [10:0] wave;
  logic        wrap;
  logic [1:0]  shape_active;

  int checks;
  int failures;

  // Model state: phase as a plain integer, wave is the sample of the previous phase.
  int m_phase;
  int m_wrap;
  int m_shape;
  int m_duty;
  int m_wave;

  wave_generator #(.P(16), .N(11), .D(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .freq        (freq),
    .shape_in    (shape_in),
    .duty_in     (duty_in),
    .sync        (sync),
    .wave        (wave),
    .wrap        (wrap),
    .shape_active(shape_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_sample(input int ph, input int sh, input int du);
    int p12;
    case (sh)
      0: return ph / 32;
      1: begin
        p12 = ph / 16;
        return (p12 < 2048) ? p12 : 4095 - p12;
      end
      2: return (ph < 32768) ? 2047 : 0;
      default: return ((ph / 256) < du) ? 2047 : 0;
    endcase
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, settle 1 ns after it.
  task automatic tick(input bit e, input bit s, input bit r, input int f, input int sh, input int du);
    int  sum;
    bit  carry;
    ena      = e;
    sync     = s;
    rst      = r;
    freq     = 16'(f);
    shape_in = 2'(sh);
    duty_in  = 8'(du);
    @(posedge clk);
    if (r) begin
      m_phase = 0;
      m_wrap  = 0;
      m_wave  = 0;
      m_shape = sh;
      m_duty  = du;
    end else begin
      m_wave = exp_sample(m_phase, m_shape, m_duty);
      sum    = m_phase + f;
      carry  = e && (sum >= 65536);
      if (s) m_phase = 0;
      else if (e) m_phase = sum % 65536;
      m_wrap = (s || carry) ? 1 : 0;
      if (s || carry) begin
        m_shape = sh;
        m_duty  = du;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    tick(0, 0, 1, 'h1000, 3, 'h20);
    checks++;
    if (shape_active !== 2'd3) begin
      failures++;
      $display("FAIL reset_shape_pulse got=%0d exp=3", shape_active);
    end
    tick(0, 0, 1, 'h1000, 0, 'h20);
    checks++;
    if (wave !== 11'd0) begin
      failures++;
      $display("FAIL reset_wave got=%h exp=0", wave);
    end
    checks++;
    if (wrap !== 1'b0) begin
      failures++;
      $display("FAIL reset_wrap got=%b exp=0", wrap);
    end
    checks++;
    if (shape_active !== 2'd0) begin
      failures++;
      $display("FAIL reset_shape_saw got=%0d exp=0", shape_active);
    end
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_saw();
    int nwrap;
    nwrap = 0;
    for (int i = 1; i <= 32; i++) begin
      tick(1, 0, 0, 'h1000, 0, 'h20);
      if (wrap === 1'b1) nwrap++;
      checks++;
      if (wave !== 11'(m_wave) || wrap !== 1'(m_wrap)) begin
        failures++;
        $display("FAIL saw_step i=%0d wave=%h exp=%h wrap=%b exp=%0d", i, wave, 11'(m_wave), wrap, m_wrap);
      end
      if (i == 2) begin
        checks++;
        if (wave !== 11'h080) begin
          failures++;
          $display("FAIL saw_first_sample got=%h exp=080", wave);
        end
      end
    end
    checks++;
    if (nwrap != 2) begin
      failures++;
      $display("FAIL saw_wrap_count got=%0d exp=2", nwrap);
    end
    $display("test_saw done wraps=%0d", nwrap);
  endtask

  task automatic test_shapes();
    int t_sh [11] = '{1, 1, 1, 2, 2, 3, 3, 3, 3, 3, 3};
    int t_du [11] = '{0, 0, 0, 0, 0, 'h40, 'h40, 0, 0, 'hFF, 'hFF};
    int t_ph [11] = '{'h4000, 'hC000, 'h8000, 'h4000, 'h8000, 'h3000, 'h4000, 'h0000, 'hF000, 'hFF00, 'hFE00};
    int t_ex [11] = '{'h400, 'h3FF, 'h7FF, 'h7FF, 0, 'h7FF, 0, 0, 0, 0, 'h7FF};
    for (int i = 0; i < 11; i++) begin
      tick(0, 1, 0, 0, t_sh[i], t_du[i]);
      tick(1, 0, 0, t_ph[i], t_sh[i], t_du[i]);
      tick(0, 0, 0, 0, t_sh[i], t_du[i]);
      checks++;
      if (wave !== 11'(t_ex[i])) begin
        failures++;
        $display("FAIL shape_table i=%0d shape=%0d duty=%h phase=%h got=%h exp=%h",
                 i, t_sh[i], t_du[i], t_ph[i], wave, 11'(t_ex[i]));
      end
      checks++;
      if (wave !== 11'(m_wave)) begin
        failures++;
        $display("FAIL shape_model i=%0d got=%h exp=%h", i, wave, 11'(m_wave));
      end
    end
    $display("test_shapes done");
  endtask

  task automatic test_shape_change();
    bit seen;
    int exp_sh;
    seen = 0;
    tick(0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 24; i++) begin
      tick(1, 0, 0, 'h1000, (i >= 5) ? 2 : 0, 0);
      if (wrap === 1'b1) seen = 1;
      exp_sh = seen ? 2 : 0;
      checks++;
      if (shape_active !== 2'(exp_sh) || wave !== 11'(m_wave)) begin
        failures++;
        $display("FAIL shape_change i=%0d shape=%0d exp=%0d wave=%h exp=%h",
                 i, shape_active, exp_sh, wave, 11'(m_wave));
      end
      if (i == 16 || i == 17) begin
        checks++;
        if (wave !== ((i == 16) ? 11'h780 : 11'h7FF)) begin
          failures++;
          $display("FAIL shape_change_edge i=%0d got=%h", i, wave);
        end
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL shape_change_wrap got=0 exp=1");
    end
    $display("test_shape_change done");
  endtask

  task automatic test_sync();
    tick(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) tick(1, 0, 0, 'h1000, 0, 0);
    tick(1, 1, 0, 'h1000, 1, 'h55);
    checks++;
    if (wrap !== 1'b1 || shape_active !== 2'd1) begin
      failures++;
      $display("FAIL sync_with_ena wrap=%b exp=1 shape=%0d exp=1", wrap, shape_active);
    end
    tick(0, 0, 0, 0, 0, 0);
    checks++;
    if (wave !== 11'd0 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL sync_phase_zero wave=%h exp=0 wrap=%b exp=0", wave, wrap);
    end
    tick(1, 0, 0, 'h3000, 3, 'h10);
    tick(0, 1, 0, 0, 3, 'h20);
    checks++;
    if (wrap !== 1'b1 || shape_active !== 2'd3) begin
      failures++;
      $display("FAIL sync_no_ena wrap=%b exp=1 shape=%0d exp=3", wrap, shape_active);
    end
    tick(0, 0, 0, 0, 0, 0);
    checks++;
    if (wave !== 11'h7FF || wave !== 11'(m_wave)) begin
      failures++;
      $display("FAIL sync_no_ena_phase got=%h exp=7ff", wave);
    end
    $display("test_sync done");
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < 5; i++) tick(1, 0, 0, $urandom_range(1, 'hFFFF), $urandom_range(0, 3), $urandom_range(0, 255));
    tick(1, 1'($urandom_range(0, 1)), 1, $urandom_range(1, 'hFFFF), 0, 0);
    checks++;
    if (wave !== 11'd0 || wrap !== 1'b0 || shape_active !== 2'd0) begin
      failures++;
      $display("FAIL rst_mid wave=%h wrap=%b shape=%0d exp=0/0/0", wave, wrap, shape_active);
    end
    for (int i = 0; i < 100; i++) begin
      tick(1, 0, 0, 0, 0, 0);
      checks++;
      if (wrap !== 1'b0 || wave !== 11'd0) begin
        failures++;
        $display("FAIL freq_zero i=%0d wrap=%b wave=%h exp=0/0", i, wrap, wave);
      end
    end
    $display("test_rst_mid done");
  endtask

  task automatic test_random();
    bit e, s, r;
    int f;
    for (int i = 0; i < 400; i++) begin
      e = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 15) == 0);
      r = ($urandom_range(0, 63) == 0);
      f = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 'hFFFF) : $urandom_range(0, 'h0FFF);
      tick(e, s, r, f, $urandom_range(0, 3), $urandom_range(0, 255));
      checks++;
      if (wave !== 11'(m_wave) || wrap !== 1'(m_wrap) || shape_active !== 2'(m_shape)) begin
        failures++;
        $display("FAIL random i=%0d wave=%h exp=%h wrap=%b exp=%0d shape=%0d exp=%0d",
                 i, wave, 11'(m_wave), wrap, m_wrap, shape_active, m_shape);
      end
    end
    $display("test_random done");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    ena      = 1'b0;
    sync     = 1'b0;
    freq     = '0;
    shape_in = '0;
    duty_in  = '0;
    #2;
    test_reset();
    test_saw();
    test_shapes();
    test_shape_change();
    test_sync();
    test_rst_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
